sort_stream_controller: RTL and testbench

// Initiator for the serial sorting-cell chain (fast_serial_sort). Accepts an unsorted frame of up to SIZE

---
 rtl/sort_stream_controller.sv | 100 ++++++++++
 tb/tb_sort_stream_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_controller.sv
// Stream front-end for the serial sorting-cell chain: fills the chain with one frame,
// drains it in ascending order, then clears the chain for the next frame.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | one cycle, sort_reset high, chain wiped, count zeroed
// ST_FILL  | accepting up to SIZE elements, each written into the chain
// ST_DRAIN | presenting the chain head downstream, shifting on each accept
module sort_stream_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_trunc,
    output logic                  sort_reset,
    output logic                  sort_enable,
    output logic                  sort_write,
    output logic [DATA_WIDTH-1:0] sort_in_data,
    input  logic [DATA_WIDTH-1:0] sort_out_data
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          accept;
    logic          take;
    logic          fill_full;

    // in_ready depends only on state/count so upstream can never create a combinational loop
    always_comb begin
        in_ready     = (state == ST_FILL) && (count < SIZE_C);
        out_valid    = (state == ST_DRAIN);
        accept       = in_valid && in_ready;
        take         = out_valid && out_ready;
        count_inc    = count + ONE_C;
        fill_full    = (count_inc == SIZE_C);
        out_data     = out_valid ? sort_out_data : '0;
        out_last     = out_valid && (count == ONE_C);
        sort_reset   = !reset_n || (state == ST_CLEAR);
        sort_enable  = accept || take;
        sort_write   = accept;
        sort_in_data = accept ? in_data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_CLEAR;
            count       <= '0;
            frame_trunc <= 1'b0;
        end else begin
            frame_trunc <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    count <= '0;
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    if (accept) begin
                        count <= count_inc;
                        if (in_last || fill_full) begin
                            state <= ST_DRAIN;
                        end
                        // chain is full but the producer has not closed the frame
                        frame_trunc <= fill_full && !in_last;
                    end
                end
                ST_DRAIN: begin
                    if (take) begin
                        count <= count - ONE_C;
                        if (out_last) begin
                            state <= ST_CLEAR;
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_stream_controller.sv
// Bench for sort_stream_controller with a behavioural sorting chain attached to its sorter pins.
module tb_sort_stream_controller;
    localparam int DW   = 8;
    localparam int SIZE = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_trunc;
    logic          sort_reset;
    logic          sort_enable;
    logic          sort_write;
    logic [DW-1:0] sort_in_data;
    logic [DW-1:0] sort_out_data = '0;

    sort_stream_controller #(.DATA_WIDTH(DW), .SIZE(SIZE)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_trunc(frame_trunc), .sort_reset(sort_reset), .sort_enable(sort_enable),
        .sort_write(sort_write), .sort_in_data(sort_in_data), .sort_out_data(sort_out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // attached sorter: ordered chain, head registered onto sort_out_data
    logic [DW-1:0] chain[$];
    int            sm_pos;
    always @(posedge clk) begin
        if (sort_reset) begin
            chain.delete();
        end else if (sort_enable && sort_write) begin
            sm_pos = chain.size();
            for (int i = chain.size() - 1; i >= 0; i--) begin
                if (chain[i] > sort_in_data) sm_pos = i;
            end
            chain.insert(sm_pos, sort_in_data);
        end else if (sort_enable && chain.size() > 0) begin
            void'(chain.pop_front());
        end
        sort_out_data <= (chain.size() > 0) ? chain[0] : '0;
    end

    // observed traffic
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] out_q[$];
    bit            outl_q[$];
    int            acc_cyc_q[$];
    int            out_cyc_q[$];
    int mcyc = 0, write_bad = 0, shift_bad = 0, both_bad = 0, clear_bad = 0;
    int trunc_seen = 0, trunc_bad = 0, stall_cycles = 0, stall_bad = 0;
    bit            stall_hold = 0;
    logic [DW-1:0] held_data = '0;

    always @(negedge clk) begin
        mcyc++;
        if (in_valid && in_ready) begin
            acc_q.push_back(in_data);
            acc_cyc_q.push_back(mcyc);
            if (!(sort_enable && sort_write && sort_in_data == in_data)) write_bad++;
        end else if (in_ready && sort_enable) begin
            write_bad++;
        end
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            outl_q.push_back(out_last);
            out_cyc_q.push_back(mcyc);
            if (!(sort_enable && !sort_write)) shift_bad++;
        end
        if (in_ready && out_valid) both_bad++;
        if (in_ready && sort_reset) clear_bad++;
        if (frame_trunc) begin
            trunc_seen++;
            if (!out_valid) trunc_bad++;
        end
        if (stall_hold && out_valid && out_data !== held_data) stall_bad++;
        if (out_valid && !out_ready) begin
            stall_cycles++;
            if (sort_enable) stall_bad++;
            held_data  = out_data;
            stall_hold = 1;
        end else begin
            stall_hold = 0;
        end
    end

    task automatic clear_mon();
        acc_q.delete(); out_q.delete(); outl_q.delete(); acc_cyc_q.delete(); out_cyc_q.delete();
        write_bad = 0; shift_bad = 0; both_bad = 0; clear_bad = 0;
        trunc_seen = 0; trunc_bad = 0; stall_cycles = 0; stall_bad = 0;
    endtask

    // reference: split into frames (last or SIZE), sort each ascending
    logic [DW-1:0] stim_d[$];
    bit            stim_l[$];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    int            exp_trunc;

    task automatic build_expected();
        logic [DW-1:0] f[$];
        logic [DW-1:0] t;
        exp_d.delete(); exp_l.delete(); exp_trunc = 0;
        for (int i = 0; i < stim_d.size(); i++) begin
            f.push_back(stim_d[i]);
            if (stim_l[i] || f.size() == SIZE) begin
                if (!stim_l[i]) exp_trunc++;
                for (int a = 0; a < f.size(); a++)
                    for (int b = 0; b + 1 < f.size() - a; b++)
                        if (f[b] > f[b+1]) begin t = f[b]; f[b] = f[b+1]; f[b+1] = t; end
                for (int j = 0; j < f.size(); j++) begin
                    exp_d.push_back(f[j]);
                    exp_l.push_back(j == f.size() - 1);
                end
                f.delete();
            end
        end
    endtask

    // mode 0: out_ready=1, mode 1: 1-0-0-1 over drain cycles, else random
    task automatic run_stream(input string name, input int mode, input int budget);
        int idx = 0;
        int cyc = 0;
        int dc  = 0;
        bit [3:0] pat = 4'b1001;
        bit timed_out = 0;
        while (1) begin
            @(posedge clk); #1;
            if (idx < stim_d.size()) begin
                in_valid = 1'b1; in_data = stim_d[idx]; in_last = stim_l[idx];
            end else begin
                in_valid = 1'b0; in_data = '0; in_last = 1'b0;
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) begin
                if (out_valid) begin out_ready = pat[dc % 4]; dc++; end
                else out_ready = 1'b1;
            end else out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (in_valid && in_ready) idx++;
            cyc++;
            if (idx == stim_d.size() && out_q.size() >= stim_d.size()) break;
            if (cyc > budget) begin timed_out = 1; break; end
        end
        in_valid = 1'b0;
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s timeout: accepted %0d emitted %0d, required %0d each", name, idx, out_q.size(), stim_d.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (sort_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sort_reset got %b want 1", sort_reset); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (frame_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_trunc got %b want 0", frame_trunc); end
        reset_n = 1'b1; #1;
        n_checks++; if (in_ready !== 1'b0 || sort_reset !== 1'b1) begin n_fail++; $display("FAIL clear_state in_ready=%b sort_reset=%b want 0/1", in_ready, sort_reset); end
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || sort_reset !== 1'b0) begin n_fail++; $display("FAIL fill_entry in_ready=%b sort_reset=%b want 1/0", in_ready, sort_reset); end
        n_checks++; if (sort_enable !== 1'b0) begin n_fail++; $display("FAIL idle_enable got %b want 0", sort_enable); end
    endtask

    task automatic test_basic();
        clear_mon();
        stim_d = '{8'd5, 8'd2, 8'd7}; stim_l = '{0, 0, 1};
        build_expected();
        run_stream("basic", 0, 100);
        n_checks++; if (out_q.size() != exp_d.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", out_q.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_d[i] || outl_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL basic_out[%0d] got %0d/%b want %0d/%b", i, out_q[i], outl_q[i], exp_d[i], exp_l[i]); end
        end
        n_checks++; if (out_cyc_q.size() == 3 && acc_cyc_q.size() == 3 && out_cyc_q[2] - acc_cyc_q[0] != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", out_cyc_q[2] - acc_cyc_q[0]); end
        n_checks++; if (shift_bad != 0 || write_bad != 0) begin n_fail++; $display("FAIL basic_sorter_ctrl shift_bad=%0d write_bad=%0d want 0", shift_bad, write_bad); end
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b0 || sort_reset !== 1'b1) begin n_fail++; $display("FAIL basic_clear in_ready=%b sort_reset=%b want 0/1", in_ready, sort_reset); end
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_refill in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_single();
        clear_mon();
        stim_d = '{8'h42}; stim_l = '{1};
        run_stream("single", 0, 100);
        n_checks++; if (out_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", out_q.size()); end
        n_checks++; if (out_q.size() > 0 && (out_q[0] !== 8'h42 || outl_q[0] !== 1'b1)) begin n_fail++; $display("FAIL single_out got %h/%b want 42/1", out_q[0], outl_q[0]); end
        n_checks++; if (write_bad != 0) begin n_fail++; $display("FAIL single_write bad=%0d want 0", write_bad); end
    endtask

    task automatic test_trunc();
        clear_mon();
        stim_d = '{8'd9, 8'd1, 8'd4, 8'd6}; stim_l = '{0, 0, 0, 1};
        build_expected();
        run_stream("trunc", 0, 100);
        n_checks++; if (out_q.size() != exp_d.size()) begin n_fail++; $display("FAIL trunc_count got %0d want %0d", out_q.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_d[i] || outl_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL trunc_out[%0d] got %0d/%b want %0d/%b", i, out_q[i], outl_q[i], exp_d[i], exp_l[i]); end
        end
        n_checks++; if (trunc_seen != exp_trunc || trunc_bad != 0) begin n_fail++; $display("FAIL trunc_pulse got %0d cycles (misplaced %0d) want %0d", trunc_seen, trunc_bad, exp_trunc); end
    endtask

    task automatic test_stall();
        clear_mon();
        stim_d = '{8'd200, 8'd17, 8'd99}; stim_l = '{0, 0, 1};
        build_expected();
        run_stream("stall", 1, 100);
        for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_d[i] || outl_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL stall_out[%0d] got %0d/%b want %0d/%b", i, out_q[i], outl_q[i], exp_d[i], exp_l[i]); end
        end
        n_checks++; if (stall_cycles != 2) begin n_fail++; $display("FAIL stall_cycles got %0d want 2", stall_cycles); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_hold violations got %0d want 0", stall_bad); end
    endtask

    task automatic test_reset_mid_drain();
        int cyc = 0;
        int idx = 0;
        clear_mon();
        stim_d = '{8'd8, 8'd2, 8'd5}; stim_l = '{0, 0, 1};
        out_ready = 1'b1;
        while (out_q.size() < 2 && cyc < 100) begin
            @(posedge clk); #1;
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? stim_d[idx] : '0;
            in_last  = (idx < 3) ? stim_l[idx] : 1'b0;
            @(negedge clk); #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        reset_n  = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_idle out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
        n_checks++; if (sort_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_sort_reset got %b want 1", sort_reset); end
        repeat (2) @(posedge clk);
        #2; reset_n = 1'b1; #1;
        n_checks++; if (out_q.size() != 2 || outl_q[0] !== 1'b0 || outl_q[1] !== 1'b0 || out_q[0] !== 8'd2 || out_q[1] !== 8'd5) begin
            n_fail++; $display("FAIL midreset_partial got %0d outputs want 2 (2,5) with no last", out_q.size()); end
        n_checks++; if (sort_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_clear got %b want 1", sort_reset); end
        clear_mon();
        stim_d = '{8'd3, 8'd3, 8'd1}; stim_l = '{0, 0, 1};
        build_expected();
        run_stream("after_reset", 0, 100);
        for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_d[i] || outl_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL dup_out[%0d] got %0d/%b want %0d/%b", i, out_q[i], outl_q[i], exp_d[i], exp_l[i]); end
        end
    endtask

    task automatic test_stream(input string name, input int n, input int mode);
        clear_mon();
        stim_d.delete(); stim_l.delete();
        for (int i = 0; i < n; i++) begin
            stim_d.push_back(DW'($urandom_range(0, 255)));
            stim_l.push_back((i == n - 1) || ($urandom_range(0, 2) == 0));
        end
        build_expected();
        run_stream(name, mode, 20 * n);
        n_checks++; if (acc_q.size() != n) begin n_fail++; $display("FAIL %s_accepted got %0d want %0d", name, acc_q.size(), n); end
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            n_checks++; if (acc_q[i] !== stim_d[i]) begin n_fail++; $display("FAIL %s_acc[%0d] got %0d want %0d", name, i, acc_q[i], stim_d[i]); end
        end
        n_checks++; if (out_q.size() != exp_d.size()) begin n_fail++; $display("FAIL %s_count got %0d want %0d", name, out_q.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_d[i] || outl_q[i] !== exp_l[i]) begin n_fail++; $display("FAIL %s_out[%0d] got %0d/%b want %0d/%b", name, i, out_q[i], outl_q[i], exp_d[i], exp_l[i]); end
        end
        n_checks++; if (trunc_seen != exp_trunc) begin n_fail++; $display("FAIL %s_trunc got %0d want %0d", name, trunc_seen, exp_trunc); end
        n_checks++; if (both_bad != 0 || clear_bad != 0 || stall_bad != 0) begin n_fail++; $display("FAIL %s_protocol both=%0d clear=%0d stall=%0d want 0", name, both_bad, clear_bad, stall_bad); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired, required completion before 1ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_trunc();
        test_stall();
        test_reset_mid_drain();
        test_stream("held_valid", 24, 0);
        test_stream("random", 60, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
